// File: rtl/fifo_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : fifo_seq_ctrl_if
// Description : Stream handshake and memory_core control bundle between the
//               FIFO sequencing controller and its environment (producer,
//               host consumer, memory_core).
// Revision    : 1.0 - initial release
// ============================================================================
interface fifo_seq_ctrl_if #(
    parameter int DEPTH_W = 16
);
    // Producer side
    logic               in_vld;
    logic               in_rdy;
    // Host consumer side
    logic               out_rdy;
    logic               out_vld;
    // memory_core side
    logic               mc_valid_out;
    logic               mc_wen_in;
    logic               mc_ren_in;
    logic               mc_clk_en;
    logic               mc_flush;
    logic               mc_tile_en;
    logic [1:0]         mc_mode;
    logic [DEPTH_W-1:0] mc_depth;

    // Controller view
    modport master (
        input  in_vld, out_rdy, mc_valid_out,
        output in_rdy, out_vld, mc_wen_in, mc_ren_in, mc_clk_en,
               mc_flush, mc_tile_en, mc_mode, mc_depth
    );

    // Environment view (producer, host and core together)
    modport slave (
        output in_vld, out_rdy, mc_valid_out,
        input  in_rdy, out_vld, mc_wen_in, mc_ren_in, mc_clk_en,
               mc_flush, mc_tile_en, mc_mode, mc_depth
    );
endinterface
`default_nettype wire

// File: rtl/fifo_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fifo_seq_ctrl
// Description : Sequencing controller for one memory_core in FIFO mode.
//               Brings the core out of idle, programs depth, flushes, then
//               runs a valid/ready stream on both sides while tracking
//               occupancy and in-flight reads so the core is never written
//               while full or read while empty.
// Options     : FIFO_SEQ_WATERMARK_EN - adds registered almost_full and
//               almost_empty outputs using AF_MARGIN.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_seq_ctrl #(
    parameter int DEPTH_W   = 16,
    parameter int RD_LAT    = 1,
    parameter int FLUSH_CYC = 2
`ifdef FIFO_SEQ_WATERMARK_EN
    ,
    parameter int AF_MARGIN = 2
`endif
) (
    input  logic               clk,
    input  logic               rst,          // asynchronous, active-low
    input  logic [DEPTH_W-1:0] cfg_depth,
    input  logic               cfg_start,
    input  logic               cfg_stop,
    output logic               cfg_err,
    output logic               busy,
    fifo_seq_ctrl_if.master    bus,
    output logic [DEPTH_W-1:0] occupancy,
    output logic               full,
    output logic               empty
`ifdef FIFO_SEQ_WATERMARK_EN
    ,
    output logic               almost_full,
    output logic               almost_empty
`endif
);

    localparam int FC_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CFG   = 3'd1,
        S_FLUSH = 3'd2,
        S_RUN   = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t             state;
    logic [DEPTH_W-1:0] depth_lat;
    logic [DEPTH_W-1:0] depth_cur;
    logic [FC_W-1:0]    flush_cnt;
    logic               tile_en;
    logic               clk_en;
    logic               flush;
    logic [DEPTH_W-1:0] inflight;

    logic               wen;
    logic               ren;
    logic               in_rdy;
    logic               rd_ret;
    logic               occ_dec;
    logic               inf_dec;

    // Write/read qualification; data itself flows producer->core untouched
    assign in_rdy  = (state == S_RUN) && (occupancy < depth_cur);
    assign wen     = bus.in_vld && in_rdy;
    assign ren     = ((state == S_RUN) || (state == S_DRAIN)) && bus.out_rdy
                     && (occupancy > inflight);
    assign rd_ret  = bus.mc_valid_out;
    // Counters hold at zero on a stray return instead of wrapping
    assign occ_dec = rd_ret && (occupancy != '0);
    assign inf_dec = rd_ret && (inflight != '0);

    assign bus.in_rdy     = in_rdy;
    assign bus.mc_wen_in  = wen;
    assign bus.mc_ren_in  = ren;
    assign bus.out_vld    = rd_ret && clk_en;
    assign bus.mc_clk_en  = clk_en;
    assign bus.mc_flush   = flush;
    assign bus.mc_tile_en = tile_en;
    assign bus.mc_mode    = 2'h1;
    assign bus.mc_depth   = depth_cur;

    // depth_cur is 0 only before the first configuration, which keeps full
    // low out of reset even though occupancy==depth_cur there
    assign full  = (depth_cur != '0) && (occupancy == depth_cur);
    assign empty = (occupancy == '0);

    // Sequencing FSM; per-state outputs are registered alongside the state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            depth_lat <= '0;
            depth_cur <= '0;
            flush_cnt <= '0;
            tile_en   <= 1'b0;
            clk_en    <= 1'b0;
            flush     <= 1'b0;
            busy      <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cfg_start) begin
                        if (cfg_depth == '0) begin
                            cfg_err <= 1'b1;
                        end else begin
                            depth_lat <= cfg_depth;
                            state     <= S_CFG;
                            tile_en   <= 1'b1;
                            clk_en    <= 1'b1;
                            busy      <= 1'b1;
                        end
                    end
                end
                S_CFG: begin
                    depth_cur <= depth_lat;
                    flush_cnt <= '0;
                    flush     <= 1'b1;
                    state     <= S_FLUSH;
                end
                S_FLUSH: begin
                    if (flush_cnt == FC_W'(FLUSH_CYC - 1)) begin
                        flush <= 1'b0;
                        state <= S_RUN;
                    end else begin
                        flush_cnt <= flush_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    if (cfg_stop) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if ((occupancy == '0) && (inflight == '0)) begin
                        state   <= S_IDLE;
                        tile_en <= 1'b0;
                        clk_en  <= 1'b0;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    tile_en <= 1'b0;
                    clk_en  <= 1'b0;
                    flush   <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // Occupancy and in-flight read tracking; cleared while the core flushes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occupancy <= '0;
            inflight  <= '0;
        end else if (state == S_FLUSH) begin
            occupancy <= '0;
            inflight  <= '0;
        end else begin
            case ({wen, occ_dec})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: occupancy <= occupancy;
            endcase
            case ({ren, inf_dec})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

`ifdef FIFO_SEQ_WATERMARK_EN
    logic [DEPTH_W-1:0] af_thresh;

    // Threshold saturates at zero for depths smaller than the margin
    assign af_thresh = (depth_cur > DEPTH_W'(AF_MARGIN))
                       ? (depth_cur - DEPTH_W'(AF_MARGIN)) : '0;

    // Watermarks are registered and trail occupancy by one cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            almost_full  <= 1'b0;
            almost_empty <= 1'b0;
        end else begin
            almost_full  <= (occupancy >= af_thresh);
            almost_empty <= (occupancy <= DEPTH_W'(AF_MARGIN));
        end
    end
`endif

    // The core must never return data the controller did not ask for
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst)
        !(bus.mc_valid_out && (occupancy == '0)));

    // With out_rdy held, outstanding reads are bounded by the core latency
    a_inflight_bound: assert property (@(posedge clk) disable iff (!rst)
        (inflight <= DEPTH_W'(RD_LAT)));

endmodule
`default_nettype wire

// File: tb/tb_fifo_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_seq_ctrl
// Description : Self-checking bench for fifo_seq_ctrl with a behavioural
//               memory_core (RD_LAT=1) and a data scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_seq_ctrl;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] cfg_depth;
    logic          cfg_start;
    logic          cfg_stop;
    logic          cfg_err;
    logic          busy;
    logic [DW-1:0] occupancy;
    logic          full;
    logic          empty;
`ifdef FIFO_SEQ_WATERMARK_EN
    logic          almost_full;
    logic          almost_empty;
`endif

    logic [15:0]   in_data;
    logic [15:0]   core_data;
    logic [15:0]   core_q[$];
    logic [15:0]   exp_q[$];
    int            total = 0;
    int            bad   = 0;
    int            wen_cnt = 0;
    int            ren_cnt = 0;
    int            vld_cnt = 0;
    logic          ren_d;

    always #5 clk = ~clk;

    fifo_seq_ctrl_if #(.DEPTH_W(DW)) bus ();

    fifo_seq_ctrl #(
        .DEPTH_W   (DW),
        .RD_LAT    (1),
        .FLUSH_CYC (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_depth (cfg_depth),
        .cfg_start (cfg_start),
        .cfg_stop  (cfg_stop),
        .cfg_err   (cfg_err),
        .busy      (busy),
        .bus       (bus),
        .occupancy (occupancy),
        .full      (full),
        .empty     (empty)
`ifdef FIFO_SEQ_WATERMARK_EN
        ,
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Behavioural memory_core: data returns one cycle after ren_in
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            core_q.delete();
            bus.mc_valid_out <= 1'b0;
            core_data        <= '0;
        end else begin
            bus.mc_valid_out <= 1'b0;
            if (bus.mc_wen_in) core_q.push_back(in_data);
            if (bus.mc_ren_in) begin
                bus.mc_valid_out <= 1'b1;
                if (core_q.size() > 0) core_data <= core_q.pop_front();
            end
        end
    end

    // Scoreboard push on every accepted producer word; handshake counters
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_q.delete();
            ren_d <= 1'b0;
        end else begin
            if (bus.mc_wen_in) begin
                exp_q.push_back(in_data);
                wen_cnt <= wen_cnt + 1;
            end
            if (bus.mc_ren_in) ren_cnt <= ren_cnt + 1;
            ren_d <= bus.mc_ren_in;
        end
    end

    // Scoreboard pop and compare whenever the host sees a word
    always @(negedge clk) begin
        if (rst && bus.out_vld) begin
            vld_cnt <= vld_cnt + 1;
            if (exp_q.size() == 0) chk("sb_underrun", 1, 0);
            else                   chk("sb_data", core_data, exp_q.pop_front());
        end
    end

    task automatic do_start(input logic [15:0] d);
        @(negedge clk);
        cfg_depth = d;
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int fl;
        int k;
        int w0, r0, v0;

        cfg_depth   = '0;
        cfg_start   = 1'b0;
        cfg_stop    = 1'b0;
        bus.in_vld  = 1'b0;
        bus.out_rdy = 1'b0;
        in_data     = '0;
        #1 rst = 1'b0;
        #11;
        // Reset state
        chk("rst_busy", busy, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_occ", occupancy, 0);
        chk("rst_mode", bus.mc_mode, 1);
        chk("rst_err", cfg_err, 0);
        chk("rst_depth", bus.mc_depth, 0);
        chk("rst_inrdy", bus.in_rdy, 0);
        chk("rst_clken", bus.mc_clk_en, 0);
        chk("rst_tile", bus.mc_tile_en, 0);
        @(negedge clk);
        rst = 1'b1;

        // Zero depth request
        do_start(16'd0);
        chk("zd_err", cfg_err, 1);
        chk("zd_busy", busy, 0);
        @(negedge clk);
        chk("zd_idle", busy, 0);

        // Initialisation: CFG, two flush cycles, RUN on the fourth cycle
        do_start(16'd4);
        chk("cfg_busy", busy, 1);
        chk("cfg_tile", bus.mc_tile_en, 1);
        chk("cfg_clken", bus.mc_clk_en, 1);
        chk("cfg_flush", bus.mc_flush, 0);
        chk("cfg_inrdy", bus.in_rdy, 0);
        fl = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.mc_flush) fl++;
        end
        chk("flush_cycles", fl, 2);
        chk("run_inrdy", bus.in_rdy, 1);
        chk("run_depth", bus.mc_depth, 4);
        chk("run_mode", bus.mc_mode, 1);
        chk("run_busy", busy, 1);

        // Fill to full with the host stalled
        w0 = wen_cnt;
        bus.in_vld = 1'b1;
        k = 0;
        for (int i = 0; i < 7; i++) begin
            if (bus.in_rdy) begin
                in_data = 16'hA001 + 16'(k);
                k++;
            end
            @(negedge clk);
        end
        chk("fill_writes", wen_cnt - w0, 4);
        chk("fill_occ", occupancy, 4);
        chk("fill_full", full, 1);
        chk("fill_empty", empty, 0);
        chk("fill_inrdy", bus.in_rdy, 0);
`ifdef FIFO_SEQ_WATERMARK_EN
        chk("wm_af", almost_full, 1);
        chk("wm_ae", almost_empty, 0);
`endif
        bus.in_vld = 1'b0;

        // Ordered read-back, one-cycle read latency
        r0 = ren_cnt;
        v0 = vld_cnt;
        bus.out_rdy = 1'b1;
        n = 0;
        while (!empty && n < 12) begin
            @(negedge clk);
            chk("rd_lat", bus.out_vld, ren_d);
            n++;
        end
        chk("order_timeout", n < 12, 1);
        bus.out_rdy = 1'b0;
        @(negedge clk);
        chk("order_reads", ren_cnt - r0, 4);
        chk("order_vlds", vld_cnt - v0, 4);
        chk("order_empty", empty, 1);
        chk("order_full", full, 0);
        chk("order_sb", exp_q.size(), 0);

        // Simultaneous write and return at occupancy 2
        bus.in_vld = 1'b1;
        in_data = 16'hB001;
        @(negedge clk);
        in_data = 16'hB002;
        @(negedge clk);
        bus.in_vld = 1'b0;
        chk("sim_pre_occ", occupancy, 2);
        bus.out_rdy = 1'b1;
        @(negedge clk);
        bus.out_rdy = 1'b0;
        chk("sim_vld", bus.out_vld, 1);
        bus.in_vld = 1'b1;
        in_data = 16'hB003;
        @(negedge clk);
        bus.in_vld = 1'b0;
        chk("sim_occ", occupancy, 2);
        chk("sim_vld_off", bus.out_vld, 0);

        // Drain from occupancy 3
        bus.in_vld = 1'b1;
        in_data = 16'hB004;
        @(negedge clk);
        bus.in_vld = 1'b0;
        chk("drn_pre_occ", occupancy, 3);
        w0 = wen_cnt;
        r0 = ren_cnt;
        cfg_stop = 1'b1;
        bus.out_rdy = 1'b1;
        @(negedge clk);
        cfg_stop = 1'b0;
        bus.in_vld = 1'b1;
        chk("drn_inrdy", bus.in_rdy, 0);
        n = 0;
        while (busy && n < 12) begin
            @(negedge clk);
            chk("drn_lat", bus.out_vld, ren_d);
            n++;
        end
        chk("drn_timeout", n < 12, 1);
        bus.in_vld = 1'b0;
        bus.out_rdy = 1'b0;
        chk("drn_reads", ren_cnt - r0, 3);
        chk("drn_writes", wen_cnt - w0, 0);
        chk("drn_clken", bus.mc_clk_en, 0);
        chk("drn_tile", bus.mc_tile_en, 0);
        chk("drn_occ", occupancy, 0);
        chk("drn_empty", empty, 1);
        chk("drn_sb", exp_q.size(), 0);

        // Asynchronous reset in the middle of a run
        do_start(16'd4);
        n = 0;
        while (!bus.in_rdy && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("rr_timeout", n < 8, 1);
        bus.in_vld = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 16'hC001 + 16'(i);
            @(negedge clk);
        end
        bus.in_vld = 1'b0;
        chk("rr_pre_occ", occupancy, 3);
        #2 rst = 1'b0;
        #1;
        chk("rr_busy", busy, 0);
        chk("rr_occ", occupancy, 0);
        chk("rr_empty", empty, 1);
        chk("rr_clken", bus.mc_clk_en, 0);
        chk("rr_inrdy", bus.in_rdy, 0);
        chk("rr_err", cfg_err, 0);
        chk("rr_depth", bus.mc_depth, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rr_stay_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_seq_ctrl.md
Name: fifo_seq_ctrl

Overview:
Sequencing controller for one memory_core instance operating as a FIFO (mode 1). It brings the core out of idle, programs depth, issues a flush, then runs a valid/ready stream on both sides by driving wen_in, ren_in and clk_en. It owns occupancy and in-flight read tracking so the core is never written while full or read while empty. It sits between a producer, a host consumer and the core.

Parameters:
DEPTH_W, 16, width of the depth and occupancy counters; depth is at most 2^DEPTH_W-1.
RD_LAT, 1, cycles from an accepted ren_in to the matching mc_valid_out; range 1-3.
FLUSH_CYC, 2, number of cycles flush is held high during initialisation.
AF_MARGIN, 2, almost-full and almost-empty margin; used only with the optional feature.

Ports:
clk  in  1  clock; all logic on posedge.
rst  in  1  reset, asynchronous, active-low.
cfg_depth  in  DEPTH_W  requested FIFO depth, sampled on cfg_start.
cfg_start  in  1  single-cycle pulse; starts initialisation from IDLE.
cfg_stop  in  1  single-cycle pulse; requests drain from RUN.
cfg_err  out  1  sticky; set when cfg_start is seen with cfg_depth==0.
busy  out  1  high in every state except IDLE.
in_vld  in  1  producer has a word.
in_rdy  out  1  controller accepts a word this cycle.
out_rdy  in  1  host can take a word.
out_vld  out  1  a word is on core data_out this cycle.
mc_valid_out  in  1  valid_out from the core.
mc_wen_in  out  1  core write enable.
mc_ren_in  out  1  core read enable.
mc_clk_en  out  1  core clock enable.
mc_flush  out  1  core flush.
mc_tile_en  out  1  core tile enable.
mc_mode  out  2  core mode; constant 2'h1.
mc_depth  out  DEPTH_W  core depth; held stable outside CFG.
occupancy  out  DEPTH_W  words written and not yet returned.
full  out  1  occupancy==mc_depth.
empty  out  1  occupancy==0.

Behaviour:
- Reset values: state=IDLE, all counters 0, mc_depth=0, cfg_err=0, all 1-bit outputs 0 except empty=1. mc_mode is 1 at all times.
- States and outputs:
  IDLE: mc_tile_en=0, mc_clk_en=0.
  CFG: 1 cycle. Loads mc_depth from the cfg_depth latched at cfg_start. mc_tile_en=1, mc_clk_en=1.
  FLUSH: mc_flush=1 for exactly FLUSH_CYC cycles. Occupancy and in-flight counters are forced to 0.
  RUN: normal streaming.
  DRAIN: in_rdy=0; reads continue.
- Transitions:
  IDLE->CFG on cfg_start && cfg_depth!=0.
  cfg_start && cfg_depth==0 sets cfg_err and stays in IDLE.
  CFG->FLUSH unconditionally.
  FLUSH->RUN after FLUSH_CYC cycles.
  RUN->DRAIN on cfg_stop.
  DRAIN->IDLE in the cycle occupancy==0 and inflight==0.
  cfg_start outside IDLE and cfg_stop outside RUN are ignored.
- Write path:
  in_rdy = (state==RUN) && (occupancy < mc_depth). No same-cycle bypass when full.
  mc_wen_in = in_vld && in_rdy. Data passes combinationally from producer to core; the controller never touches data.
- Read path:
  inflight counts ren_in pulses whose data has not yet returned.
  mc_ren_in = (RUN or DRAIN) && out_rdy && (occupancy > inflight).
  inflight increments on mc_ren_in and decrements on mc_valid_out; both in one cycle means no change.
  out_vld = mc_valid_out && mc_clk_en.
- Occupancy:
  +1 on mc_wen_in, -1 on mc_valid_out. Both in the same cycle means no change.
  Never wraps. mc_valid_out while occupancy==0 is an assertion failure, and the counter holds at 0.
- mc_clk_en = 1 in CFG, FLUSH, RUN and DRAIN.
- The host must hold out_rdy until the read data returns. Data arrives RD_LAT cycles after mc_ren_in.
- An asynchronous reset mid-stream returns the block to IDLE immediately and discards all counts. Recovery requires a new cfg_start.
- cfg_err clears only on reset.

Optional Feature:
FIFO_SEQ_WATERMARK_EN adds two outputs:
- almost_full = occupancy >= mc_depth-AF_MARGIN, with the subtraction saturating at 0.
- almost_empty = occupancy <= AF_MARGIN.
Both are registered, so they lag occupancy by 1 cycle, and both reset to 0. Without the macro the ports do not exist, and the related logic and parameter use are compiled out.

Test Plan:
- Init: cfg_depth=4, pulse cfg_start -> CFG for 1 cycle, mc_flush high for 2 cycles, RUN in cycle 4, mc_depth=4, mc_mode=1, busy=1.
- Fill: in_vld=1, out_rdy=0, depth 4 -> 4 writes accepted, occupancy=4, full=1, in_rdy=0 from the next cycle, no 5th mc_wen_in.
- Order: write 16'hA001..16'hA004, then out_rdy=1 -> 4 mc_ren_in pulses, out_vld 1 cycle after each (RD_LAT=1) with data A001..A004 in order, then empty=1.
- Simultaneous: occupancy=2, in_vld=1 and a mc_valid_out in the same cycle -> occupancy stays 2; inflight never exceeds occupancy.
- Drain: cfg_stop with occupancy=3 and out_rdy=1 -> in_rdy=0 immediately, 3 reads, then IDLE with mc_clk_en=0. Zero depth: cfg_start with cfg_depth=0 -> cfg_err=1, stays in IDLE.
- Reset mid-run: assert rst low with occupancy=3 -> state IDLE, occupancy=0, empty=1 with no clock edge needed.
